sine_gen: RTL and testbench

SINE_GEN -- requirements
Module: sine_gen

---
 rtl/sine_gen_pkg.sv | 42 ++++
 rtl/sine_qlut.sv | 22 ++
 rtl/sine_gen.sv | 195 +++++++++++++++++++
 tb/tb_sine_gen.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sine_gen_pkg.sv
// Shared constants, quadrant type and quarter-wave table generator for sine_gen.
package sine_gen_pkg;

  localparam int CARRIER_TOP_DEF = 5000;
  localparam int MID             = 2500;
  localparam int SAMPLE_W        = 13;
  localparam int LUT_AW          = 8;
  localparam int LUT_DW          = 12;
  localparam int LUT_DEPTH       = 32'sd1 << LUT_AW;

  typedef enum logic [1:0] {
    QUAD_0 = 2'd0,
    QUAD_1 = 2'd1,
    QUAD_2 = 2'd2,
    QUAD_3 = 2'd3
  } quad_t;

  // pi scaled by 2^30 (hex digits of pi: 3.243F6A88...)
  localparam longint PI_Q30 = 64'sd3373259426;

  // Elaboration-time entry i = round(2500*sin(pi/2*(i+0.5)/256)) via a Q30 Taylor series.
  function automatic logic [LUT_DW-1:0] qlut_entry(input int idx);
    longint x;
    longint x2;
    longint term;
    longint acc;
    x    = (PI_Q30 * longint'(32'sd2 * idx + 32'sd1)) / 64'sd1024;
    x2   = (x * x) >>> 6'd30;
    term = x;
    acc  = x;
    for (int k = 1; k <= 8; k++) begin
      term = ((term * x2) >>> 6'd30) / longint'(32'sd4 * k * k + 32'sd2 * k);
      if ((k % 32'sd2) == 32'sd1) begin
        acc = acc - term;
      end else begin
        acc = acc + term;
      end
    end
    return LUT_DW'((acc * 64'sd2500 + 64'sd536870912) >>> 6'd30);
  endfunction

endpackage

// File: rtl/sine_qlut.sv
// Quarter-wave sine ROM (256 x 12) with a registered read port.
module sine_qlut
  import sine_gen_pkg::*;
(
  input  logic              clk,
  input  logic [LUT_AW-1:0] addr,
  output logic [LUT_DW-1:0] data
);

  logic [LUT_DW-1:0] rom_s [LUT_DEPTH];

  for (genvar g = 0; g < LUT_DEPTH; g++) begin : g_rom
    localparam logic [LUT_DW-1:0] ENTRY = qlut_entry(g);
    assign rom_s[g] = ENTRY;
  end

  // registered ROM read
  always_ff @(posedge clk) begin
    data <= rom_s[addr];
  end

endmodule

// File: rtl/sine_gen.sv
// Sine sample generator for a PWM stage: phase accumulator, quarter-wave LUT, clamp.
// Optional amplitude scaling stage is enabled by defining SINE_GEN_AMP_EN.
module sine_gen
  import sine_gen_pkg::*;
#(
  parameter int CARRIER_TOP = CARRIER_TOP_DEF,
  parameter int PHASE_W     = 24
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic [PHASE_W-1:0]  phase_inc,
`ifdef SINE_GEN_AMP_EN
  input  logic [7:0]          amp,
`endif
  output logic [SAMPLE_W-1:0] Sine_out,
  output logic                sample_valid
);

  localparam int                  CNT_W   = $clog2(CARRIER_TOP + 1);
  localparam logic [CNT_W-1:0]    CNT_TOP = CNT_W'(CARRIER_TOP);
  localparam logic [SAMPLE_W-1:0] MID_S   = SAMPLE_W'(MID);

  logic [CNT_W-1:0]    cnt_r;
  logic                tick_s;
  logic [PHASE_W-1:0]  acc_r;
  logic [9:0]          phase_idx_s;
  quad_t               quad_s;
  logic [LUT_AW-1:0]   addr_s;

  logic                s1_valid_r;
  logic                s1_mid_r;
  quad_t               s1_quad_r;
  logic [LUT_AW-1:0]   s1_addr_r;

  logic                s2_valid_r;
  logic                s2_mid_r;
  quad_t               s2_quad_r;
  logic [LUT_DW-1:0]   lut_data_s;

  logic                fin_valid_s;
  logic                fin_mid_s;
  quad_t               fin_quad_s;
  logic [LUT_DW-1:0]   fin_mag_s;
  int                  sum_s;
  logic [SAMPLE_W-1:0] next_out_s;

  // carrier counter, wraps after CARRIER_TOP
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= '0;
    end else if (tick_s) begin
      cnt_r <= '0;
    end else begin
      cnt_r <= cnt_r + 1'b1;
    end
  end

  assign tick_s = (cnt_r == CNT_TOP);

  // quadrant decode and mirrored LUT address
  always_comb begin
    phase_idx_s = acc_r[PHASE_W-1 -: 10];
    quad_s      = quad_t'(phase_idx_s[9:8]);
    case (quad_s)
      QUAD_0, QUAD_2: addr_s = phase_idx_s[7:0];
      QUAD_1, QUAD_3: addr_s = ~phase_idx_s[7:0];
      default:        addr_s = phase_idx_s[7:0];
    endcase
  end

`ifdef SINE_GEN_AMP_EN
  logic [7:0] s1_amp_r;
  logic [7:0] s2_amp_r;
`endif

  // stage 1: phase accumulator and tick-time capture of quadrant/address
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_r      <= '0;
      s1_valid_r <= 1'b0;
      s1_mid_r   <= 1'b0;
      s1_quad_r  <= QUAD_0;
      s1_addr_r  <= '0;
`ifdef SINE_GEN_AMP_EN
      s1_amp_r   <= 8'd0;
`endif
    end else begin
      s1_valid_r <= tick_s;
      if (tick_s) begin
        s1_mid_r  <= ~en;
        s1_quad_r <= quad_s;
        s1_addr_r <= addr_s;
`ifdef SINE_GEN_AMP_EN
        s1_amp_r  <= amp;
`endif
        if (en) begin
          acc_r <= acc_r + phase_inc;
        end
      end
    end
  end

  sine_qlut u_qlut (
    .clk  (clk),
    .addr (s1_addr_r),
    .data (lut_data_s)
  );

  // stage 2: side-band travels alongside the ROM read
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid_r <= 1'b0;
      s2_mid_r   <= 1'b0;
      s2_quad_r  <= QUAD_0;
`ifdef SINE_GEN_AMP_EN
      s2_amp_r   <= 8'd0;
`endif
    end else begin
      s2_valid_r <= s1_valid_r;
      s2_mid_r   <= s1_mid_r;
      s2_quad_r  <= s1_quad_r;
`ifdef SINE_GEN_AMP_EN
      s2_amp_r   <= s1_amp_r;
`endif
    end
  end

`ifdef SINE_GEN_AMP_EN
  logic              s3_valid_r;
  logic              s3_mid_r;
  quad_t             s3_quad_r;
  logic [LUT_DW-1:0] s3_mag_r;
  logic [19:0]       prod_s;

  assign prod_s = lut_data_s * s2_amp_r;

  // stage 3: amplitude scaling, amp/256
  always_ff @(posedge clk) begin
    if (rst) begin
      s3_valid_r <= 1'b0;
      s3_mid_r   <= 1'b0;
      s3_quad_r  <= QUAD_0;
      s3_mag_r   <= '0;
    end else begin
      s3_valid_r <= s2_valid_r;
      s3_mid_r   <= s2_mid_r;
      s3_quad_r  <= s2_quad_r;
      s3_mag_r   <= prod_s[19:8];
    end
  end

  assign fin_valid_s = s3_valid_r;
  assign fin_mid_s   = s3_mid_r;
  assign fin_quad_s  = s3_quad_r;
  assign fin_mag_s   = s3_mag_r;
`else
  assign fin_valid_s = s2_valid_r;
  assign fin_mid_s   = s2_mid_r;
  assign fin_quad_s  = s2_quad_r;
  assign fin_mag_s   = lut_data_s;
`endif

  // signed reconstruction around the midpoint, clamped to the carrier range
  always_comb begin
    if (fin_mid_s) begin
      sum_s = MID;
    end else if ((fin_quad_s == QUAD_0) || (fin_quad_s == QUAD_1)) begin
      sum_s = MID + int'(fin_mag_s);
    end else begin
      sum_s = MID - int'(fin_mag_s);
    end
    if (sum_s < 32'sd0) begin
      next_out_s = '0;
    end else if (sum_s > CARRIER_TOP) begin
      next_out_s = SAMPLE_W'(CARRIER_TOP);
    end else begin
      next_out_s = SAMPLE_W'(sum_s);
    end
  end

  // output register and one-clock valid pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      Sine_out     <= MID_S;
      sample_valid <= 1'b0;
    end else begin
      sample_valid <= fin_valid_s;
      if (fin_valid_s) begin
        Sine_out <= next_out_s;
      end
    end
  end

endmodule

// File: tb/tb_sine_gen.sv
// Randomized self-checking bench for sine_gen against a real-valued sine model.
module tb_sine_gen;

  localparam int TOP  = 5000;
  localparam int PW   = 24;
  localparam int MIDV = 2500;
`ifdef SINE_GEN_AMP_EN
  localparam int LAT  = 4;
  localparam int AMPP = 128;
`else
  localparam int LAT  = 3;
  localparam int AMPP = 256;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en = 1'b1;
  logic [PW-1:0] phase_inc = '0;
`ifdef SINE_GEN_AMP_EN
  logic [7:0]    amp = 8'd128;
`endif
  logic [12:0]   sine_out;
  logic          sample_valid;

  int checks = 0;
  int errors = 0;
  int cyc_abs = 0;
  int obs_val[$];
  int obs_cyc[$];
  int due_q[$];
  int val_q[$];
  int seq_exp[4];

  sine_gen #(.CARRIER_TOP(TOP), .PHASE_W(PW)) dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .phase_inc    (phase_inc),
`ifdef SINE_GEN_AMP_EN
    .amp          (amp),
`endif
    .Sine_out     (sine_out),
    .sample_valid (sample_valid)
  );

  always #5 clk = ~clk;

  // Ideal sample: midpoint plus rounded 2500*sin at the centre of the 10-bit phase bin.
  function automatic int model_sample(input logic [PW-1:0] acc, input logic en_s, input int amp_v);
    real ang;
    real s;
    int  pos;
    int  mag;
    int  v;
    if (!en_s) return MIDV;
    pos = int'(acc[PW-1 -: 10]);
    ang = 2.0 * 3.141592653589793 * (real'(pos) + 0.5) / 1024.0;
    s   = $sin(ang);
    mag = $rtoi($floor(2500.0 * ((s < 0.0) ? -s : s) + 0.5));
    mag = (mag * amp_v) >> 8;
    v   = (s < 0.0) ? MIDV - mag : MIDV + mag;
    if (v < 0) v = 0;
    if (v > TOP) v = TOP;
    return v;
  endfunction

  task automatic check_eq(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int get_obs(input int i);
    if (i < obs_val.size()) return obs_val[i];
    return -1;
  endfunction

  function automatic int get_cyc(input int i);
    if (i < obs_cyc.size()) return obs_cyc[i];
    return -1;
  endfunction

  task automatic wait_pulses(input int n);
    int budget;
    budget = 0;
    while (obs_val.size() < n && budget < 2 * (TOP + 1) + 20) begin
      @(negedge clk);
      budget++;
    end
    if (obs_val.size() < n) begin
      checks++;
      errors++;
      $display("FAIL pulse_timeout: got %0d pulses, expected %0d", obs_val.size(), n);
    end
  endtask

  task automatic wiggle();
    repeat (50) begin
      @(negedge clk);
      en        = 1'($urandom_range(0, 1));
      phase_inc = PW'($urandom);
`ifdef SINE_GEN_AMP_EN
      amp       = 8'($urandom);
`endif
    end
  endtask

  // Model update at each rising edge, comparison at each falling edge.
  initial begin : model_check
    bit            armed;
    bit            exp_valid;
    int            exp_out;
    int            m_c;
    int            r_amp;
    logic          r_rst;
    logic          r_en;
    logic [PW-1:0] r_inc;
    logic [PW-1:0] m_acc;
    armed = 1'b0; exp_valid = 1'b0; exp_out = MIDV; m_c = 0; m_acc = '0;
    forever begin
      @(posedge clk);
      r_rst = rst;
      r_en  = en;
      r_inc = phase_inc;
`ifdef SINE_GEN_AMP_EN
      r_amp = int'(amp);
`else
      r_amp = 256;
`endif
      cyc_abs++;
      if (r_rst) begin
        armed = 1'b1;
        m_c = 0;
        m_acc = '0;
        due_q.delete();
        val_q.delete();
        exp_out = MIDV;
        exp_valid = 1'b0;
      end else if (armed) begin
        if (m_c >= TOP && ((m_c - TOP) % (TOP + 1)) == 0) begin
          due_q.push_back(m_c + LAT);
          val_q.push_back(model_sample(m_acc, r_en, r_amp));
          if (r_en) m_acc = m_acc + r_inc;
        end
        m_c++;
        if (due_q.size() > 0 && due_q[0] == m_c) begin
          exp_valid = 1'b1;
          exp_out = val_q[0];
          void'(due_q.pop_front());
          void'(val_q.pop_front());
        end else begin
          exp_valid = 1'b0;
        end
      end
      @(negedge clk);
      if (armed) begin
        checks++;
        if (sample_valid !== exp_valid || sine_out !== 13'(exp_out)) begin
          errors++;
          $display("FAIL cycle %0d: sample_valid=%0b Sine_out=%0d, expected sample_valid=%0b Sine_out=%0d",
                   cyc_abs, sample_valid, sine_out, exp_valid, exp_out);
        end
        if (sample_valid === 1'b1) begin
          obs_val.push_back(int'(sine_out));
          obs_cyc.push_back(cyc_abs);
        end
      end
    end
  end

  initial begin : stimulus
    int rel_abs;
    int target;
    int n_before;
    int budget;
`ifdef SINE_GEN_AMP_EN
    seq_exp = '{2504, 3750, 2496, 1250};
`else
    seq_exp = '{2508, 5000, 2492, 0};
`endif
    check_eq("model_q0", model_sample(24'h000000, 1'b1, AMPP), seq_exp[0]);
    check_eq("model_q1", model_sample(24'h400000, 1'b1, AMPP), seq_exp[1]);
    check_eq("model_q2", model_sample(24'h800000, 1'b1, AMPP), seq_exp[2]);
    check_eq("model_q3", model_sample(24'hC00000, 1'b1, AMPP), seq_exp[3]);
    check_eq("model_hold", model_sample(24'h123456, 1'b0, AMPP), MIDV);

    repeat (3) @(negedge clk);
    check_eq("reset_out", int'(sine_out), MIDV);
    check_eq("reset_valid", int'(sample_valid), 0);
    rst = 1'b0;
    rel_abs = cyc_abs;

    wait_pulses(2);
    check_eq("first_latency", get_cyc(0) - rel_abs, TOP + LAT);
    check_eq("pulse_spacing", get_cyc(1) - get_cyc(0), TOP + 1);
    check_eq("inc0_s0", get_obs(0), seq_exp[0]);
    check_eq("inc0_s1", get_obs(1), seq_exp[0]);

    wiggle();
    en = 1'b1; phase_inc = 24'h400000;
`ifdef SINE_GEN_AMP_EN
    amp = 8'd128;
`endif
    wait_pulses(4);
    check_eq("quad_s0", get_obs(2), seq_exp[0]);
    check_eq("quad_s1", get_obs(3), seq_exp[1]);

    wiggle();
    en = 1'b0; phase_inc = 24'h400000;
`ifdef SINE_GEN_AMP_EN
    amp = 8'd128;
`endif
    wait_pulses(6);
    check_eq("hold_s0", get_obs(4), MIDV);
    check_eq("hold_s1", get_obs(5), MIDV);

    wiggle();
    en = 1'b1; phase_inc = 24'h400000;
`ifdef SINE_GEN_AMP_EN
    amp = 8'd128;
`endif
    wait_pulses(8);
    check_eq("resume_s2", get_obs(6), seq_exp[2]);
    check_eq("resume_s3", get_obs(7), seq_exp[3]);

    // reset asserted in the cycle after the next tick
    target = get_cyc(7) - LAT + TOP + 2;
    budget = 0;
    while (cyc_abs < target && budget < 2 * (TOP + 1)) begin
      @(negedge clk);
      budget++;
    end
    check_eq("reset_align", cyc_abs, target);
    n_before = obs_val.size();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    rel_abs = cyc_abs;
    repeat (20) @(negedge clk);
    check_eq("flush_no_pulse", obs_val.size(), n_before);
    check_eq("flush_out_mid", int'(sine_out), MIDV);

    wait_pulses(n_before + 1);
    check_eq("post_reset_latency", get_cyc(n_before) - rel_abs, TOP + LAT);
    check_eq("post_reset_s0", get_obs(n_before), seq_exp[0]);

    for (int r = 0; r < 2; r++) begin
      wiggle();
      phase_inc = PW'($urandom);
      en = ($urandom_range(0, 3) != 0);
      wait_pulses(n_before + 2 + r);
    end
    repeat (5) @(negedge clk);
    check_eq("no_pending", due_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
